// File: rtl/dram_request_arbiter.sv
// ---------------------------------------------------------------------------
// dram_request_arbiter
//
// Shares the single UberDDR3 request port among three requesters: audio
// sample reads, video frame-buffer writes and video frame-buffer reads.
// A new grant decision is made every clock cycle. Audio normally wins.
// The two video requesters alternate round-robin. A per-requester wait
// counter lets a video requester that has waited too long preempt audio.
// A credit counter limits how many requests can be in flight at the
// controller.
//
// The grant path is purely combinational, so a valid request can reach
// memrequest_en in the same cycle.
//
// Parameters:
//   STARVE_LIMIT    cycles a valid video requester may wait before it
//                   preempts audio
//   MAX_OUTSTANDING maximum number of issued but uncompleted requests
//   OUT_W           width of the outstanding counter
//
// Ports:
//   clk_dram_ctrl, rst_dram_ctrl   controller clock, async active-high reset
//   enable                         low blocks every grant
//   aud_rd_*                       audio read request (valid/ready/addr)
//   vid_wr_*                       video write request (valid/ready/addr/data)
//   vid_rd_*                       video read request (valid/ready/addr)
//   memrequest_*                   request port towards the DDR3 controller
//   last_grant                     registered: 0 none, 1 aud, 2 vid_wr, 3 vid_rd
//   outstanding                    number of requests currently in flight
// ---------------------------------------------------------------------------
module dram_request_arbiter #(
    parameter int STARVE_LIMIT    = 16,
    parameter int MAX_OUTSTANDING = 32,
    parameter int OUT_W           = 6
) (
    input  logic              clk_dram_ctrl,
    input  logic              rst_dram_ctrl,
    input  logic              enable,

    input  logic              aud_rd_valid,
    output logic              aud_rd_ready,
    input  logic [23:0]       aud_rd_addr,

    input  logic              vid_wr_valid,
    output logic              vid_wr_ready,
    input  logic [23:0]       vid_wr_addr,
    input  logic [127:0]      vid_wr_data,

    input  logic              vid_rd_valid,
    output logic              vid_rd_ready,
    input  logic [23:0]       vid_rd_addr,

    output logic [23:0]       memrequest_addr,
    output logic              memrequest_en,
    output logic [127:0]      memrequest_write_data,
    output logic              memrequest_write_enable,
    input  logic              memrequest_busy,
    input  logic              memrequest_complete,

    output logic [1:0]        last_grant,
    output logic [OUT_W-1:0]  outstanding
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_AUD  = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } grant_t;

    // rr_ptr = 0 favours vid_wr, 1 favours vid_rd
    logic              rr_ptr;
    logic [WAIT_W-1:0] wait_wr;
    logic [WAIT_W-1:0] wait_rd;

    logic   can_issue;
    logic   starved_wr;
    logic   starved_rd;
    logic   video_grant;
    logic   any_grant;
    grant_t grant;

    // A starved requester only counts while it is still asking; a counter
    // left at the limit by a request that just dropped must not win.
    assign can_issue  = enable && !memrequest_busy &&
                        (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign starved_wr = vid_wr_valid && (wait_wr == WAIT_W'(STARVE_LIMIT));
    assign starved_rd = vid_rd_valid && (wait_rd == WAIT_W'(STARVE_LIMIT));

    // Grant selection. Reset is folded in so nothing is handed out while
    // the block is held in reset, even with valids already asserted.
    always_comb begin
        grant = GNT_NONE;
        if (can_issue && !rst_dram_ctrl) begin
            if (starved_wr && starved_rd) begin
                grant = rr_ptr ? GNT_RD : GNT_WR;
            end else if (starved_wr) begin
                grant = GNT_WR;
            end else if (starved_rd) begin
                grant = GNT_RD;
            end else if (aud_rd_valid) begin
                grant = GNT_AUD;
            end else if (vid_wr_valid && vid_rd_valid) begin
                grant = rr_ptr ? GNT_RD : GNT_WR;
            end else if (vid_wr_valid) begin
                grant = GNT_WR;
            end else if (vid_rd_valid) begin
                grant = GNT_RD;
            end
        end
    end

    assign any_grant   = (grant != GNT_NONE);
    assign video_grant = (grant == GNT_WR) || (grant == GNT_RD);

    // Request port mux: address and data are zeroed on idle cycles so the
    // controller never sees stale values alongside a low strobe.
    always_comb begin
        aud_rd_ready            = 1'b0;
        vid_wr_ready            = 1'b0;
        vid_rd_ready            = 1'b0;
        memrequest_en           = any_grant;
        memrequest_addr         = 24'd0;
        memrequest_write_data   = 128'd0;
        memrequest_write_enable = 1'b0;
        case (grant)
            GNT_AUD: begin
                aud_rd_ready    = 1'b1;
                memrequest_addr = aud_rd_addr;
            end
            GNT_WR: begin
                vid_wr_ready            = 1'b1;
                memrequest_addr         = vid_wr_addr;
                memrequest_write_data   = vid_wr_data;
                memrequest_write_enable = 1'b1;
            end
            GNT_RD: begin
                vid_rd_ready    = 1'b1;
                memrequest_addr = vid_rd_addr;
            end
            default: begin
            end
        endcase
    end

    // Arbitration state. The round-robin pointer moves to the video
    // requester that was not just served, so a lone requester granted while
    // its partner was idle hands the next turn to the partner.
    always_ff @(posedge clk_dram_ctrl or posedge rst_dram_ctrl) begin
        if (rst_dram_ctrl) begin
            rr_ptr     <= 1'b0;
            wait_wr    <= '0;
            wait_rd    <= '0;
            last_grant <= 2'd0;
        end else begin
            if (video_grant) begin
                rr_ptr <= (grant == GNT_WR);
            end

            if (!vid_wr_valid || grant == GNT_WR) begin
                wait_wr <= '0;
            end else if (wait_wr != WAIT_W'(STARVE_LIMIT)) begin
                wait_wr <= wait_wr + WAIT_W'(1);
            end

            if (!vid_rd_valid || grant == GNT_RD) begin
                wait_rd <= '0;
            end else if (wait_rd != WAIT_W'(STARVE_LIMIT)) begin
                wait_rd <= wait_rd + WAIT_W'(1);
            end

            if (any_grant) begin
                last_grant <= grant;
            end
        end
    end

    // In-flight credit counter. A completion with nothing outstanding is
    // treated as spurious and dropped rather than wrapping the count.
    always_ff @(posedge clk_dram_ctrl or posedge rst_dram_ctrl) begin
        if (rst_dram_ctrl) begin
            outstanding <= '0;
        end else begin
            case ({any_grant, memrequest_complete})
                2'b10: outstanding <= outstanding + OUT_W'(1);
                2'b01: begin
                    if (outstanding != '0) begin
                        outstanding <= outstanding - OUT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_request_arbiter
//
// Self-checking bench for dram_request_arbiter. A small behavioural model
// (plain integers: per-requester wait counts, which video requester is
// favoured, in-flight count, last grant) predicts each cycle's grant.
// Directed scenarios plus a randomized run compare the DUT against it.
// ---------------------------------------------------------------------------
module tb_dram_request_arbiter;

    localparam int STARVE = 16;
    localparam int MAXO   = 32;

    logic         clk_dram_ctrl = 1'b0;
    logic         rst_dram_ctrl;
    logic         enable;
    logic         aud_rd_valid;
    logic         aud_rd_ready;
    logic [23:0]  aud_rd_addr;
    logic         vid_wr_valid;
    logic         vid_wr_ready;
    logic [23:0]  vid_wr_addr;
    logic [127:0] vid_wr_data;
    logic         vid_rd_valid;
    logic         vid_rd_ready;
    logic [23:0]  vid_rd_addr;
    logic [23:0]  memrequest_addr;
    logic         memrequest_en;
    logic [127:0] memrequest_write_data;
    logic         memrequest_write_enable;
    logic         memrequest_busy;
    logic         memrequest_complete;
    logic [1:0]   last_grant;
    logic [5:0]   outstanding;

    int checks = 0;
    int errors = 0;

    // model state
    int m_wait_wr, m_wait_rd, m_fav_rd, m_inflight, m_last;

    dram_request_arbiter #(
        .STARVE_LIMIT(STARVE),
        .MAX_OUTSTANDING(MAXO),
        .OUT_W(6)
    ) dut (
        .clk_dram_ctrl(clk_dram_ctrl),
        .rst_dram_ctrl(rst_dram_ctrl),
        .enable(enable),
        .aud_rd_valid(aud_rd_valid),
        .aud_rd_ready(aud_rd_ready),
        .aud_rd_addr(aud_rd_addr),
        .vid_wr_valid(vid_wr_valid),
        .vid_wr_ready(vid_wr_ready),
        .vid_wr_addr(vid_wr_addr),
        .vid_wr_data(vid_wr_data),
        .vid_rd_valid(vid_rd_valid),
        .vid_rd_ready(vid_rd_ready),
        .vid_rd_addr(vid_rd_addr),
        .memrequest_addr(memrequest_addr),
        .memrequest_en(memrequest_en),
        .memrequest_write_data(memrequest_write_data),
        .memrequest_write_enable(memrequest_write_enable),
        .memrequest_busy(memrequest_busy),
        .memrequest_complete(memrequest_complete),
        .last_grant(last_grant),
        .outstanding(outstanding)
    );

    always #5 clk_dram_ctrl = ~clk_dram_ctrl;

    // Model: who should win this cycle, from the arbitration rules.
    function automatic int model_grant();
        bit ok;
        bit sw;
        bit sr;
        ok = enable && !memrequest_busy && (m_inflight < MAXO);
        sw = vid_wr_valid && (m_wait_wr == STARVE);
        sr = vid_rd_valid && (m_wait_rd == STARVE);
        if (!ok) return 0;
        if (sw && sr) return m_fav_rd ? 3 : 2;
        if (sw) return 2;
        if (sr) return 3;
        if (aud_rd_valid) return 1;
        if (vid_wr_valid && vid_rd_valid) return m_fav_rd ? 3 : 2;
        if (vid_wr_valid) return 2;
        if (vid_rd_valid) return 3;
        return 0;
    endfunction

    // Model: advance state across one clock edge given this cycle's grant.
    function automatic void model_commit(int g);
        if (!vid_wr_valid || g == 2) m_wait_wr = 0;
        else m_wait_wr = (m_wait_wr + 1 > STARVE) ? STARVE : m_wait_wr + 1;
        if (!vid_rd_valid || g == 3) m_wait_rd = 0;
        else m_wait_rd = (m_wait_rd + 1 > STARVE) ? STARVE : m_wait_rd + 1;
        if (g == 2) m_fav_rd = 1;
        if (g == 3) m_fav_rd = 0;
        if (g != 0 && !memrequest_complete) m_inflight++;
        else if (g == 0 && memrequest_complete && m_inflight > 0) m_inflight--;
        if (g != 0) m_last = g;
    endfunction

    function automatic void model_reset();
        m_wait_wr = 0; m_wait_rd = 0; m_fav_rd = 0; m_inflight = 0; m_last = 0;
    endfunction

    // Decode the DUT's ready outputs into a grant code (4 = more than one).
    function automatic int obs_grant();
        int n;
        n = int'(aud_rd_ready) + int'(vid_wr_ready) + int'(vid_rd_ready);
        if (n > 1) return 4;
        if (aud_rd_ready) return 1;
        if (vid_wr_ready) return 2;
        if (vid_rd_ready) return 3;
        return 0;
    endfunction

    function automatic logic [23:0] exp_addr(int g);
        case (g)
            1: return aud_rd_addr;
            2: return vid_wr_addr;
            3: return vid_rd_addr;
            default: return 24'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        enable = 1'b1;
        aud_rd_valid = 1'b0; vid_wr_valid = 1'b0; vid_rd_valid = 1'b0;
        aud_rd_addr = 24'd0; vid_wr_addr = 24'd0; vid_rd_addr = 24'd0;
        vid_wr_data = 128'd0;
        memrequest_busy = 1'b0; memrequest_complete = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_dram_ctrl = 1'b1;
        repeat (2) @(negedge clk_dram_ctrl);
        rst_dram_ctrl = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int g;
        clear_inputs();
        rst_dram_ctrl = 1'b1;
        @(negedge clk_dram_ctrl);
        aud_rd_valid = 1'b1;
        aud_rd_addr  = 24'h00ABCD;
        #1;
        checks++;
        if (aud_rd_ready !== 1'b0 || memrequest_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold_ready: ready=%b en=%b expected 0/0", aud_rd_ready, memrequest_en);
        end
        @(negedge clk_dram_ctrl);
        rst_dram_ctrl = 1'b0;
        aud_rd_valid  = 1'b0;
        model_reset();
        #1;
        checks++;
        if (outstanding !== 6'd0 || last_grant !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: outstanding=%0d last_grant=%0d expected 0/0", outstanding, last_grant);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_dram_ctrl);
            aud_rd_valid = 1'b1;
            #1;
            g = model_grant();
            checks++;
            if (obs_grant() !== g) begin
                errors++;
                $display("[TB] FAIL reset_fill_grant: got %0d expected %0d", obs_grant(), g);
            end
            model_commit(g);
        end
        @(negedge clk_dram_ctrl);
        #1;
        checks++;
        if (outstanding !== 6'd5 || last_grant !== 2'd1) begin
            errors++;
            $display("[TB] FAIL reset_prefill: outstanding=%0d last_grant=%0d expected 5/1", outstanding, last_grant);
        end
        #2;
        rst_dram_ctrl = 1'b1;
        #1;
        checks++;
        if (outstanding !== 6'd0 || last_grant !== 2'd0 || aud_rd_ready !== 1'b0 || memrequest_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: outstanding=%0d last_grant=%0d ready=%b en=%b expected 0/0/0/0",
                     outstanding, last_grant, aud_rd_ready, memrequest_en);
        end
        @(negedge clk_dram_ctrl);
        rst_dram_ctrl = 1'b0;
        aud_rd_valid  = 1'b0;
        model_reset();
    endtask

    task automatic test_audio_starve();
        int g;
        int want;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            @(negedge clk_dram_ctrl);
            aud_rd_valid = 1'b1; vid_wr_valid = 1'b1; vid_rd_valid = 1'b1;
            aud_rd_addr = 24'h000010; vid_wr_addr = 24'h000020; vid_rd_addr = 24'h000030;
            memrequest_complete = 1'b1;
            #1;
            want = (i < 16) ? 1 : (i == 16) ? 2 : (i == 17) ? 3 : 1;
            g = model_grant();
            checks++;
            if (obs_grant() !== want || g !== want) begin
                errors++;
                $display("[TB] FAIL starve_cycle%0d: got %0d model %0d expected %0d", i, obs_grant(), g, want);
            end
            checks++;
            if (memrequest_addr !== exp_addr(want)) begin
                errors++;
                $display("[TB] FAIL starve_addr%0d: got %h expected %h", i, memrequest_addr, exp_addr(want));
            end
            model_commit(g);
        end
        checks++;
        if (outstanding !== 6'd0) begin
            errors++;
            $display("[TB] FAIL starve_outstanding: got %0d expected 0", outstanding);
        end
        clear_inputs();
    endtask

    task automatic test_video_rr();
        int g;
        int want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_dram_ctrl);
            vid_wr_valid = 1'b1; vid_rd_valid = 1'b1;
            vid_wr_addr  = 24'h000100; vid_rd_addr = 24'h000200;
            vid_wr_data  = {$urandom, $urandom, $urandom, $urandom};
            memrequest_complete = 1'b1;
            #1;
            want = (i % 2 == 0) ? 2 : 3;
            g = model_grant();
            checks++;
            if (obs_grant() !== want || g !== want) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got %0d model %0d expected %0d", i, obs_grant(), g, want);
            end
            checks++;
            if (memrequest_write_enable !== (want == 2) ||
                memrequest_addr !== ((want == 2) ? 24'h000100 : 24'h000200) ||
                memrequest_write_data !== ((want == 2) ? vid_wr_data : 128'd0)) begin
                errors++;
                $display("[TB] FAIL rr_port%0d: we=%b addr=%h data=%h expected we=%b", i,
                         memrequest_write_enable, memrequest_addr, memrequest_write_data, want == 2);
            end
            model_commit(g);
        end
        clear_inputs();
    endtask

    task automatic test_credit();
        int g;
        int grants;
        do_reset();
        grants = 0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk_dram_ctrl);
            vid_rd_valid = 1'b1; vid_rd_addr = 24'(i);
            #1;
            g = model_grant();
            if (obs_grant() != 0) grants++;
            checks++;
            if (obs_grant() !== g) begin
                errors++;
                $display("[TB] FAIL credit_grant%0d: got %0d expected %0d", i, obs_grant(), g);
            end
            model_commit(g);
        end
        @(negedge clk_dram_ctrl);
        memrequest_complete = 1'b1;
        #1;
        checks++;
        if (grants !== 32 || outstanding !== 6'd32 || vid_rd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL credit_cap: grants=%0d outstanding=%0d ready=%b expected 32/32/0",
                     grants, outstanding, vid_rd_ready);
        end
        model_commit(model_grant());
        grants = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_dram_ctrl);
            memrequest_complete = 1'b0;
            #1;
            g = model_grant();
            if (obs_grant() != 0) grants++;
            model_commit(g);
        end
        checks++;
        if (grants !== 1) begin
            errors++;
            $display("[TB] FAIL credit_refill: grants=%0d expected 1", grants);
        end
        @(negedge clk_dram_ctrl);
        memrequest_complete = 1'b1;
        #1;
        model_commit(model_grant());
        @(negedge clk_dram_ctrl);
        #1;
        g = model_grant();
        checks++;
        if (outstanding !== 6'd31 || obs_grant() !== 3 || g !== 3) begin
            errors++;
            $display("[TB] FAIL credit_pre_both: outstanding=%0d grant=%0d expected 31/3", outstanding, obs_grant());
        end
        model_commit(g);
        @(negedge clk_dram_ctrl);
        memrequest_complete = 1'b0;
        vid_rd_valid = 1'b0;
        #1;
        checks++;
        if (outstanding !== 6'd31 || m_inflight !== 31) begin
            errors++;
            $display("[TB] FAIL credit_both: outstanding=%0d expected 31", outstanding);
        end
        clear_inputs();
    endtask

    task automatic test_busy();
        int g;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_dram_ctrl);
            aud_rd_valid    = 1'b1;
            aud_rd_addr     = 24'h5A5A00 + 24'(i);
            memrequest_busy = (i < 10);
            #1;
            g = model_grant();
            checks++;
            if (memrequest_en !== (i == 10) || g !== ((i == 10) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL busy_en%0d: got %b expected %b", i, memrequest_en, i == 10);
            end
            if (i == 10) begin
                checks++;
                if (memrequest_addr !== aud_rd_addr) begin
                    errors++;
                    $display("[TB] FAIL busy_addr: got %h expected %h", memrequest_addr, aud_rd_addr);
                end
            end
            model_commit(g);
        end
        clear_inputs();
    endtask

    task automatic test_enable_starve();
        int g;
        int want;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            @(negedge clk_dram_ctrl);
            enable = (i >= 20);
            aud_rd_valid = 1'b1; vid_wr_valid = 1'b1; vid_rd_valid = 1'b1;
            aud_rd_addr = 24'h111111; vid_wr_addr = 24'h222222; vid_rd_addr = 24'h333333;
            #1;
            want = (i < 20) ? 0 : (i == 20) ? 2 : (i == 21) ? 3 : 1;
            g = model_grant();
            checks++;
            if (obs_grant() !== want || memrequest_en !== (want != 0) || g !== want) begin
                errors++;
                $display("[TB] FAIL enable_cycle%0d: got %0d en=%b expected %0d", i, obs_grant(), memrequest_en, want);
            end
            model_commit(g);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_dram_ctrl);
            if ($urandom_range(7) == 0) aud_rd_valid = ~aud_rd_valid;
            if ($urandom_range(7) == 0) vid_wr_valid = ~vid_wr_valid;
            if ($urandom_range(7) == 0) vid_rd_valid = ~vid_rd_valid;
            enable              = ($urandom_range(7) != 0);
            memrequest_busy     = ($urandom_range(3) == 0);
            memrequest_complete = ($urandom_range(3) == 0);
            aud_rd_addr = 24'($urandom);
            vid_wr_addr = 24'($urandom);
            vid_rd_addr = 24'($urandom);
            vid_wr_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            g = model_grant();
            checks++;
            if (obs_grant() !== g || memrequest_en !== (g != 0)) begin
                errors++;
                $display("[TB] FAIL rand_grant%0d: got %0d en=%b expected %0d", i, obs_grant(), memrequest_en, g);
            end
            checks++;
            if (memrequest_addr !== exp_addr(g) || memrequest_write_enable !== (g == 2) ||
                memrequest_write_data !== ((g == 2) ? vid_wr_data : 128'd0)) begin
                errors++;
                $display("[TB] FAIL rand_port%0d: addr=%h we=%b expected addr=%h we=%b", i,
                         memrequest_addr, memrequest_write_enable, exp_addr(g), g == 2);
            end
            checks++;
            if (int'(outstanding) !== m_inflight || int'(last_grant) !== m_last) begin
                errors++;
                $display("[TB] FAIL rand_state%0d: outstanding=%0d last=%0d expected %0d/%0d", i,
                         outstanding, last_grant, m_inflight, m_last);
            end
            model_commit(g);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_dram_ctrl = 1'b1;
        model_reset();
        $display("[TB] starting dram_request_arbiter bench");
        test_reset();
        test_audio_starve();
        test_video_rr();
        test_credit();
        test_busy();
        test_enable_starve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
